// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arithmetic ops plus iterative unsigned MULU/DIVU behind valid/ready.
// Optional macro ALU_DIV_EN enables the restoring divider; otherwise DIVU completes in one cycle flagging Overflow.
module alu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] Result_hi,
    output logic             Overflow,
    output logic             CarryOut,
    output logic             Zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   result_hi_q;
    logic               ovf_q;
    logic               carry_q;

    logic               accept_c;
    logic               multi_c;
    logic               sub_c;
    logic [WIDTH-1:0]   b_eff_c;
    logic [WIDTH:0]     sum_c;
    logic               ovf_c;
    logic [WIDTH-1:0]   sc_res_c;
    logic               sc_ovf_c;
    logic               sc_carry_c;

    logic [WIDTH:0]     mul_sum_c;
    logic [2*WIDTH-1:0] mul_acc_d;
    logic [WIDTH-1:0]   fin_res_c;
    logic [WIDTH-1:0]   fin_hi_c;
    logic               fin_ovf_c;

`ifdef ALU_DIV_EN
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   rem_q;
    logic               is_div_q;
    logic [WIDTH:0]     div_shift_c;
    logic [WIDTH:0]     div_diff_c;
    logic               div_ge_c;
    logic [WIDTH-1:0]   rem_d;
    logic [WIDTH-1:0]   quo_d;
`endif

    assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
    assign accept_c  = in_valid & in_ready;
    assign out_valid = (state_q == S_DONE);
    assign Result    = result_q;
    assign Result_hi = result_hi_q;
    assign Overflow  = ovf_q;
    assign CarryOut  = carry_q;
    assign Zero      = (result_q == '0);

`ifdef ALU_DIV_EN
    assign multi_c = (ALUop == OP_MULU) || (ALUop == OP_DIVU);
`else
    assign multi_c = (ALUop == OP_MULU);
`endif

    // Single-cycle ops share one WIDTH+1 adder; SUB/SLT use A + ~B + 1.
    always_comb begin
        sub_c      = (ALUop == OP_SUB) || (ALUop == OP_SLT);
        b_eff_c    = sub_c ? ~B : B;
        sum_c      = {1'b0, A} + {1'b0, b_eff_c} + (WIDTH+1)'(sub_c);
        ovf_c      = (A[WIDTH-1] == b_eff_c[WIDTH-1]) && (sum_c[WIDTH-1] != A[WIDTH-1]);
        sc_res_c   = '0;
        sc_ovf_c   = 1'b0;
        sc_carry_c = 1'b0;
        case (ALUop)
            OP_AND: sc_res_c = A & B;
            OP_OR:  sc_res_c = A | B;
            OP_ADD: begin
                sc_res_c   = sum_c[WIDTH-1:0];
                sc_ovf_c   = ovf_c;
                sc_carry_c = sum_c[WIDTH];
            end
            OP_SUB: begin
                sc_res_c   = sum_c[WIDTH-1:0];
                sc_ovf_c   = ovf_c;
                sc_carry_c = ~sum_c[WIDTH];
            end
            OP_SLT: begin
                sc_res_c   = WIDTH'(sum_c[WIDTH-1] ^ ovf_c);
                sc_ovf_c   = ovf_c;
                sc_carry_c = ~sum_c[WIDTH];
            end
`ifndef ALU_DIV_EN
            OP_DIVU: sc_ovf_c = 1'b1;
`endif
            default: ;
        endcase
    end

    // Shift-add multiply: low half starts as B and is consumed LSB first.
    assign mul_sum_c = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    assign mul_acc_d = {mul_sum_c, acc_q[WIDTH-1:1]};

`ifdef ALU_DIV_EN
    // Restoring divide: low half of acc holds dividend bits, shifted out as quotient bits shift in.
    assign div_shift_c = {rem_q, acc_q[WIDTH-1]};
    assign div_diff_c  = div_shift_c - {1'b0, b_q};
    assign div_ge_c    = ~div_diff_c[WIDTH];
    assign rem_d       = div_ge_c ? div_diff_c[WIDTH-1:0] : div_shift_c[WIDTH-1:0];
    assign quo_d       = {acc_q[WIDTH-2:0], div_ge_c};
`endif

    always_comb begin
        fin_res_c = mul_acc_d[WIDTH-1:0];
        fin_hi_c  = mul_acc_d[2*WIDTH-1:WIDTH];
        fin_ovf_c = |mul_acc_d[2*WIDTH-1:WIDTH];
`ifdef ALU_DIV_EN
        if (is_div_q) begin
            if (b_q == '0) begin
                fin_res_c = '1;
                fin_hi_c  = a_q;
                fin_ovf_c = 1'b1;
            end else begin
                fin_res_c = quo_d;
                fin_hi_c  = rem_d;
                fin_ovf_c = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            ovf_q       <= 1'b0;
            carry_q     <= 1'b0;
`ifdef ALU_DIV_EN
            b_q         <= '0;
            rem_q       <= '0;
            is_div_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_BUSY: begin
`ifdef ALU_DIV_EN
                    acc_q <= is_div_q ? {{WIDTH{1'b0}}, quo_d} : mul_acc_d;
                    rem_q <= rem_d;
`else
                    acc_q <= mul_acc_d;
`endif
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q     <= S_DONE;
                        result_q    <= fin_res_c;
                        result_hi_q <= fin_hi_c;
                        ovf_q       <= fin_ovf_c;
                        carry_q     <= 1'b0;
                    end
                end
                default: begin
                    if (accept_c) begin
                        if (multi_c) begin
                            state_q <= S_BUSY;
                            cnt_q   <= '0;
                            a_q     <= A;
`ifdef ALU_DIV_EN
                            acc_q    <= {{WIDTH{1'b0}}, (ALUop == OP_DIVU) ? A : B};
                            b_q      <= B;
                            rem_q    <= '0;
                            is_div_q <= (ALUop == OP_DIVU);
`else
                            acc_q    <= {{WIDTH{1'b0}}, B};
`endif
                        end else begin
                            state_q     <= S_DONE;
                            result_q    <= sc_res_c;
                            result_hi_q <= '0;
                            ovf_q       <= sc_ovf_c;
                            carry_q     <= sc_carry_c;
                        end
                    end else if ((state_q == S_DONE) && out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Randomised bench for alu_seq (WIDTH=32) against an arithmetic reference model with cycle-accurate handshake checks.
module tb_alu_seq;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALUop;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Result;
    logic [31:0] Result_hi;
    logic        Overflow;
    logic        CarryOut;
    logic        Zero;

    logic ready_fix;
    logic rnd_ready;
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_fail = 0;

    typedef struct {
        logic [31:0] r;
        logic [31:0] h;
        logic        o;
        logic        c;
        int          lat;
        int          acc;
    } exp_t;

    exp_t exp_q[$];

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .ALUop(ALUop), .out_valid(out_valid), .out_ready(out_ready),
        .Result(Result), .Result_hi(Result_hi), .Overflow(Overflow),
        .CarryOut(CarryOut), .Zero(Zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        exp_t        e;
        longint      sa;
        longint      sb;
        longint      s;
        logic [63:0] p;
        e.r = '0; e.h = '0; e.o = 1'b0; e.c = 1'b0; e.lat = 1; e.acc = 0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_AND: e.r = a & b;
            OP_OR:  e.r = a | b;
            OP_ADD: begin
                p   = {32'b0, a} + {32'b0, b};
                e.r = p[31:0];
                e.c = p[32];
                s   = sa + sb;
                e.o = (s > MAXS) || (s < MINS);
            end
            OP_SUB, OP_SLT: begin
                e.r = (op == OP_SUB) ? a - b : {31'b0, (sa < sb)};
                e.c = (a < b);
                s   = sa - sb;
                e.o = (s > MAXS) || (s < MINS);
            end
            OP_MULU: begin
                p     = {32'b0, a} * {32'b0, b};
                e.r   = p[31:0];
                e.h   = p[63:32];
                e.o   = (e.h != 0);
                e.lat = 33;
            end
            OP_DIVU: begin
`ifdef ALU_DIV_EN
                if (b == 0) begin
                    e.r = 32'hFFFF_FFFF;
                    e.h = a;
                    e.o = 1'b1;
                end else begin
                    e.r = a / b;
                    e.h = a % b;
                end
                e.lat = 33;
`else
                e.o = 1'b1;
`endif
            end
            default: ;
        endcase
        return e;
    endfunction

    // Per-cycle compare of handshake and payload against the expected-result queue.
    always @(negedge clk) begin
        exp_t e;
        logic ev;
        logic er;
        if (!resetn) begin
            exp_q.delete();
        end else begin
            ev = (exp_q.size() != 0) && (cyc - exp_q[0].acc + 1 >= exp_q[0].lat);
            er = (exp_q.size() == 0) || (ev && out_ready);
            chk("out_valid", 64'(out_valid), 64'(ev));
            chk("in_ready", 64'(in_ready), 64'(er));
            if (ev) begin
                chk("Result", 64'(Result), 64'(exp_q[0].r));
                chk("Result_hi", 64'(Result_hi), 64'(exp_q[0].h));
                chk("Overflow", 64'(Overflow), 64'(exp_q[0].o));
                chk("CarryOut", 64'(CarryOut), 64'(exp_q[0].c));
                chk("Zero", 64'(Zero), 64'(exp_q[0].r == 0));
            end
            if (ev && out_ready) void'(exp_q.pop_front());
            if (in_valid && er) begin
                e     = model(A, B, ALUop);
                e.acc = cyc + 1;
                exp_q.push_back(e);
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_fix;
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        int n;
        @(posedge clk);
        #1;
        A = a; B = b; ALUop = op; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pin(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                       input logic [31:0] r, input logic [31:0] h, input logic o, input logic c);
        exp_t e;
        e = model(a, b, op);
        chk("pin_r", 64'(e.r), 64'(r));
        chk("pin_h", 64'(e.h), 64'(h));
        chk("pin_o", 64'(e.o), 64'(o));
        chk("pin_c", 64'(e.c), 64'(c));
        send(a, b, op);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'(0));
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [3:0] rnd_op();
        case ($urandom_range(0, 8))
            0:       return OP_AND;
            1:       return OP_OR;
            2:       return OP_ADD;
            3:       return OP_SUB;
            4:       return OP_SLT;
            5:       return OP_MULU;
            6:       return OP_DIVU;
            7:       return 4'($urandom_range(0, 15));
            default: return OP_SLT;
        endcase
    endfunction

    initial begin
        resetn = 1'b0; in_valid = 1'b0; A = '0; B = '0; ALUop = '0;
        ready_fix = 1'b1; rnd_ready = 1'b0;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_Result", 64'(Result), 64'(0));
        chk("rst_Result_hi", 64'(Result_hi), 64'(0));
        chk("rst_flags", 64'({Overflow, CarryOut}), 64'(0));
        chk("rst_Zero", 64'(Zero), 64'(1));
        @(posedge clk);
        @(posedge clk);
        #1 resetn = 1'b1;

        pin(32'h7FFF_FFFF, 32'h1, OP_ADD, 32'h8000_0000, 32'h0, 1'b1, 1'b0);
        pin(32'd5, 32'd5, OP_SUB, 32'h0, 32'h0, 1'b0, 1'b0);
        pin(32'd3, 32'd5, OP_SUB, 32'hFFFF_FFFE, 32'h0, 1'b0, 1'b1);
        pin(32'h8000_0000, 32'h1, OP_SLT, 32'h1, 32'h0, 1'b1, 1'b0);
        pin(32'h1, 32'h8000_0000, OP_SLT, 32'h0, 32'h0, 1'b1, 1'b1);
        pin(32'hFFFF_FFFF, 32'h2, OP_MULU, 32'hFFFF_FFFE, 32'h1, 1'b1, 1'b0);
`ifdef ALU_DIV_EN
        pin(32'd100, 32'd7, OP_DIVU, 32'd14, 32'd2, 1'b0, 1'b0);
        pin(32'd100, 32'd0, OP_DIVU, 32'hFFFF_FFFF, 32'd100, 1'b1, 1'b0);
`else
        pin(32'd100, 32'd7, OP_DIVU, 32'h0, 32'h0, 1'b1, 1'b0);
`endif
        pin(32'h1234, 32'h5678, 4'b0011, 32'h0, 32'h0, 1'b0, 1'b0);
        pin(32'hF0F0_1234, 32'h0FF0_FF00, OP_AND, 32'h00F0_1200, 32'h0, 1'b0, 1'b0);
        drain();

        // Back-to-back single-cycle ops with the consumer always ready.
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            A = $urandom; B = $urandom; ALUop = (i % 2 == 0) ? OP_SLT : OP_ADD;
            in_valid = 1'b1;
            @(negedge clk);
            chk("b2b_in_ready", 64'(in_ready), 64'(1));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();

        // Backpressure: result held in DONE while the consumer stalls.
        ready_fix = 1'b0;
        @(posedge clk);
        send(32'd10, 32'd20, OP_ADD);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'(1));
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            chk("bp_Result", 64'(Result), 64'(30));
        end
        ready_fix = 1'b1;
        drain();

        // Asynchronous reset in the middle of a multiply.
        send(32'd1, 32'd1, OP_ADD);
        drain();
        send(32'h1234_5678, 32'h9ABC_DEF0, OP_MULU);
        repeat (5) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'(0));
        chk("arst_Zero", 64'(Zero), 64'(1));
        chk("arst_Result", 64'(Result), 64'(0));
        @(negedge clk);
        @(posedge clk);
        #1 resetn = 1'b1;
        pin(32'd2, 32'd3, OP_ADD, 32'd5, 32'd0, 1'b0, 1'b0);
        drain();

        rnd_ready = 1'b1;
        for (int i = 0; i < 300; i++) send(rnd_val(), rnd_val(), rnd_op());
        rnd_ready = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
